decode_cycle: RTL and testbench

- Second stage of the 5-stage RV32I pipeline; consumes InstrD, PCD and PCPlus4D from the fetch stage's IF/ID register.
- Decodes the instruction, reads the 32x32 register file (written back from WB), sign-extends the immediate, and registers everything into the ID/EX pipeline register for the execute stage.
- Exports Rs1D/Rs2D combinationally to the hazard unit; accepts FlushE from it.

---
 rtl/decode_cycle_pkg.sv | 63 ++++++
 rtl/decode_cycle_if.sv | 47 ++++
 rtl/decode_cycle_register_file.sv | 33 +++
 rtl/decode_cycle.sv | 178 +++++++++++++++++
 tb/tb_decode_cycle.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/decode_cycle_pkg.sv
// Shared definitions for the RV32I decode stage: widths, opcodes,
// control encodings and the ID/EX pipeline register layout.
package decode_cycle_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int REG_AW = 5;

  // Opcodes recognised by the main decoder; anything else decodes as a bubble.
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctl_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  // Everything the execute stage sees; an all-zero value is a harmless NOP.
  typedef struct packed {
    logic              reg_write;
    logic              mem_write;
    logic              jump;
    logic              branch;
    logic              alu_src;
    result_src_e       result_src;
    alu_ctl_e          alu_control;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm_ext;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_plus4;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
  } idex_t;

endpackage

// File: rtl/decode_cycle_if.sv
// Bundle of the decode stage's pipeline-facing signals: IF/ID inputs,
// writeback port, hazard-unit signals and the ID/EX outputs.
interface decode_cycle_if;
  import decode_cycle_pkg::*;

  logic              FlushE;
  logic [XLEN-1:0]   InstrD;
  logic [XLEN-1:0]   PCD;
  logic [XLEN-1:0]   PCPlus4D;
  logic              RegWriteW;
  logic [REG_AW-1:0] RdW;
  logic [XLEN-1:0]   ResultW;
  logic [REG_AW-1:0] Rs1D;
  logic [REG_AW-1:0] Rs2D;
  logic              RegWriteE;
  logic              MemWriteE;
  logic              JumpE;
  logic              BranchE;
  logic              ALUSrcE;
  logic [1:0]        ResultSrcE;
  logic [2:0]        ALUControlE;
  logic [XLEN-1:0]   RD1E;
  logic [XLEN-1:0]   RD2E;
  logic [XLEN-1:0]   ImmExtE;
  logic [XLEN-1:0]   PCE;
  logic [XLEN-1:0]   PCPlus4E;
  logic [REG_AW-1:0] Rs1E;
  logic [REG_AW-1:0] Rs2E;
  logic [REG_AW-1:0] RdE;

  // Driver side: fetch, writeback and hazard logic feeding the stage.
  modport master (
    output FlushE, InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW,
    input  Rs1D, Rs2D, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
    input  ResultSrcE, ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
    input  Rs1E, Rs2E, RdE
  );

  // The decode stage itself.
  modport slave (
    input  FlushE, InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW,
    output Rs1D, Rs2D, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
    output ResultSrcE, ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
    output Rs1E, Rs2E, RdE
  );

endinterface

// File: rtl/decode_cycle_register_file.sv
// 32x32 architectural register file: two combinational read ports with
// write-through bypass, one synchronous write port, x0 hardwired to zero.
module decode_cycle_register_file
  import decode_cycle_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ra [2],
  output logic [XLEN-1:0]   rd [2],
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [XLEN-1:0]   wd
);

  logic [XLEN-1:0] regs [NREGS];

  // Reset clears the whole array; a write arriving with reset is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '{default: '0};
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  // Each read port returns zero for x0 and forwards the in-flight write.
  for (genvar gi = 0; gi < 2; gi++) begin : g_read
    assign rd[gi] = (ra[gi] == '0)             ? '0 :
                    (we && (wa == ra[gi]))     ? wd :
                                                 regs[ra[gi]];
  end

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: main/ALU decode, immediate extension, register
// file read and the ID/EX pipeline register with reset/flush bubbles.
module decode_cycle
  import decode_cycle_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  decode_cycle_if.slave bus
);

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              funct7b5;
  logic              op5;

  logic              reg_write;
  logic              mem_write;
  logic              jump;
  logic              branch;
  logic              alu_src;
  imm_src_e          imm_src;
  result_src_e       result_src;
  alu_op_e           alu_op;
  alu_ctl_e          alu_control;
  logic [XLEN-1:0]   imm_ext;

  logic [REG_AW-1:0] rf_ra [2];
  logic [XLEN-1:0]   rf_rd [2];

  idex_t             idex_reg;
  idex_t             idex_next;

  assign opcode   = bus.InstrD[6:0];
  assign funct3   = bus.InstrD[14:12];
  assign funct7b5 = bus.InstrD[30];
  assign op5      = bus.InstrD[5];

  // Source fields go straight to the hazard unit.
  assign bus.Rs1D = bus.InstrD[19:15];
  assign bus.Rs2D = bus.InstrD[24:20];

  assign rf_ra[0] = bus.InstrD[19:15];
  assign rf_ra[1] = bus.InstrD[24:20];

  decode_cycle_register_file u_register_file (
    .clk (clk),
    .rst (rst),
    .ra  (rf_ra),
    .rd  (rf_rd),
    .we  (bus.RegWriteW),
    .wa  (bus.RdW),
    .wd  (bus.ResultW)
  );

  // Main decoder; unknown opcodes leave every control at zero.
  always_comb begin
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    jump       = 1'b0;
    branch     = 1'b0;
    alu_src    = 1'b0;
    imm_src    = IMM_I;
    result_src = RES_ALU;
    alu_op     = ALUOP_ADD;
    case (opcode)
      OP_LW: begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        result_src = RES_MEM;
      end
      OP_SW: begin
        imm_src   = IMM_S;
        alu_src   = 1'b1;
        mem_write = 1'b1;
      end
      OP_RTYPE: begin
        reg_write = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      OP_BEQ: begin
        imm_src = IMM_B;
        branch  = 1'b1;
        alu_op  = ALUOP_SUB;
      end
      OP_IALU: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      OP_JAL: begin
        reg_write  = 1'b1;
        imm_src    = IMM_J;
        result_src = RES_PC4;
        jump       = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU decoder; subtract only for R-type with funct7[5] set.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

  // Immediate extension, always sign-extended from bit 31.
  always_comb begin
    imm_ext = '0;
    case (imm_src)
      IMM_I: imm_ext = {{20{bus.InstrD[31]}}, bus.InstrD[31:20]};
      IMM_S: imm_ext = {{20{bus.InstrD[31]}}, bus.InstrD[31:25], bus.InstrD[11:7]};
      IMM_B: imm_ext = {{20{bus.InstrD[31]}}, bus.InstrD[7], bus.InstrD[30:25],
                        bus.InstrD[11:8], 1'b0};
      IMM_J: imm_ext = {{12{bus.InstrD[31]}}, bus.InstrD[19:12], bus.InstrD[20],
                        bus.InstrD[30:21], 1'b0};
      default: imm_ext = '0;
    endcase
  end

  // Assemble the next ID/EX contents from the decoded fields.
  always_comb begin
    idex_next             = '0;
    idex_next.reg_write   = reg_write;
    idex_next.mem_write   = mem_write;
    idex_next.jump        = jump;
    idex_next.branch      = branch;
    idex_next.alu_src     = alu_src;
    idex_next.result_src  = result_src;
    idex_next.alu_control = alu_control;
    idex_next.rd1         = rf_rd[0];
    idex_next.rd2         = rf_rd[1];
    idex_next.imm_ext     = imm_ext;
    idex_next.pc          = bus.PCD;
    idex_next.pc_plus4    = bus.PCPlus4D;
    idex_next.rs1         = bus.InstrD[19:15];
    idex_next.rs2         = bus.InstrD[24:20];
    idex_next.rd          = bus.InstrD[11:7];
  end

  // ID/EX register: reset and flush both insert an all-zero bubble.
  always_ff @(posedge clk) begin
    if (rst || bus.FlushE) begin
      idex_reg <= '0;
    end else begin
      idex_reg <= idex_next;
    end
  end

  assign bus.RegWriteE   = idex_reg.reg_write;
  assign bus.MemWriteE   = idex_reg.mem_write;
  assign bus.JumpE       = idex_reg.jump;
  assign bus.BranchE     = idex_reg.branch;
  assign bus.ALUSrcE     = idex_reg.alu_src;
  assign bus.ResultSrcE  = idex_reg.result_src;
  assign bus.ALUControlE = idex_reg.alu_control;
  assign bus.RD1E        = idex_reg.rd1;
  assign bus.RD2E        = idex_reg.rd2;
  assign bus.ImmExtE     = idex_reg.imm_ext;
  assign bus.PCE         = idex_reg.pc;
  assign bus.PCPlus4E    = idex_reg.pc_plus4;
  assign bus.Rs1E        = idex_reg.rs1;
  assign bus.Rs2E        = idex_reg.rs2;
  assign bus.RdE         = idex_reg.rd;

endmodule

// File: tb/tb_decode_cycle.sv
// Bench for decode_cycle: directed cases with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_decode_cycle;

  typedef struct packed {
    logic        rw, mw, j, b, as;
    logic [1:0]  rs;
    logic [2:0]  alu;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
  } e_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [31:0] mregs [32];
  e_t   exp_e;

  decode_cycle_if dif();

  decode_cycle dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic e_t dut_pack();
    e_t v;
    v.rw  = dif.RegWriteE;  v.mw  = dif.MemWriteE; v.j  = dif.JumpE;
    v.b   = dif.BranchE;    v.as  = dif.ALUSrcE;   v.rs = dif.ResultSrcE;
    v.alu = dif.ALUControlE;
    v.rd1 = dif.RD1E;  v.rd2 = dif.RD2E; v.imm = dif.ImmExtE;
    v.pc  = dif.PCE;   v.pc4 = dif.PCPlus4E;
    v.rs1 = dif.Rs1E;  v.rs2 = dif.Rs2E; v.rd  = dif.RdE;
    return v;
  endfunction

  // Architectural read: x0 is zero, an in-flight write is visible at once.
  function automatic logic [31:0] rf_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (dif.RegWriteW && dif.RdW == a) return dif.ResultW;
    return mregs[a];
  endfunction

  // Expected ID/EX contents for one instruction, straight from the ISA tables.
  function automatic e_t model(input logic [31:0] ins);
    e_t v;
    logic [6:0] op;
    v  = '0;
    op = ins[6:0];
    // Immediate format follows the opcode; unknown opcodes use I-format.
    if (op == 7'b0100011)
      v.imm = 32'($signed({ins[31:25], ins[11:7]}));
    else if (op == 7'b1100011)
      v.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    else if (op == 7'b1101111)
      v.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    else
      v.imm = 32'($signed(ins[31:20]));
    case (op)
      7'b0000011: begin v.rw = 1; v.as = 1; v.rs = 2'b01; end
      7'b0100011: begin v.mw = 1; v.as = 1; end
      7'b1100011: begin v.b = 1; v.alu = 3'b001; end
      7'b1101111: begin v.rw = 1; v.j = 1; v.rs = 2'b10; end
      7'b0110011, 7'b0010011: begin
        v.rw = 1;
        v.as = (op == 7'b0010011);
        case (ins[14:12])
          3'b000:  v.alu = (op == 7'b0110011 && ins[30]) ? 3'b001 : 3'b000;
          3'b010:  v.alu = 3'b101;
          3'b110:  v.alu = 3'b011;
          3'b111:  v.alu = 3'b010;
          default: v.alu = 3'b000;
        endcase
      end
      default: ;
    endcase
    v.rd1 = rf_read(ins[19:15]);
    v.rd2 = rf_read(ins[24:20]);
    v.pc  = dif.PCD;
    v.pc4 = dif.PCPlus4D;
    v.rs1 = ins[19:15];
    v.rs2 = ins[24:20];
    v.rd  = ins[11:7];
    return v;
  endfunction

  // Model step at each edge, then compare the DUT a little after the edge.
  always @(posedge clk) begin
    if (rst || dif.FlushE) exp_e = '0;
    else                   exp_e = model(dif.InstrD);
    if (rst) mregs = '{default: '0};
    else if (dif.RegWriteW && dif.RdW != 5'd0) mregs[dif.RdW] = dif.ResultW;
    #2;
    check("idex", 192'(dut_pack()), 192'(exp_e));
    check("rs1d", 192'(dif.Rs1D), 192'(dif.InstrD[19:15]));
    check("rs2d", 192'(dif.Rs2D), 192'(dif.InstrD[24:20]));
  end

  task automatic drive(input logic r, input logic [31:0] ins, input logic fl,
                       input logic rw, input logic [4:0] rdw, input logic [31:0] res);
    @(negedge clk);
    rst           = r;
    dif.InstrD    = ins;
    dif.FlushE    = fl;
    dif.RegWriteW = rw;
    dif.RdW       = rdw;
    dif.ResultW   = res;
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    dif.FlushE = 0; dif.InstrD = 0; dif.PCD = 0; dif.PCPlus4D = 0;
    dif.RegWriteW = 0; dif.RdW = 0; dif.ResultW = 0;

    // Reset, then zero instructions: everything stays zero.
    drive(1, 32'h0, 0, 0, 5'd0, 32'h0); settle();
    drive(0, 32'h0, 0, 0, 5'd0, 32'h0); settle();
    drive(0, 32'h0, 0, 0, 5'd0, 32'h0); settle();
    check("reset_zero", 192'(dut_pack()), 192'(0));
    for (int a = 0; a < 32; a++) begin
      drive(0, {7'd0, 5'(a), 5'(a), 3'd0, 5'd1, 7'b0110011}, 0, 0, 5'd0, 32'h0);
      settle();
      check("reset_rd", 192'({dif.RD1E, dif.RD2E}), 192'(0));
    end

    // add x1,x5,x0 with a write to x5 in the same cycle: bypass.
    drive(0, 32'h000280B3, 0, 1, 5'd5, 32'hDEADBEEF); settle();
    check("bypass_rd1", 192'(dif.RD1E), 192'(32'hDEADBEEF));
    check("add_regwrite", 192'(dif.RegWriteE), 192'(1));
    check("add_alu", 192'(dif.ALUControlE), 192'(3'b000));
    check("add_rd", 192'(dif.RdE), 192'(5'd1));

    // Write to x0 is ignored and not bypassed; then sub decodes to 001.
    drive(0, 32'h000000B3, 0, 1, 5'd0, 32'h1234); settle();
    check("x0_bypass", 192'(dif.RD1E), 192'(0));
    drive(0, 32'h000000B3, 0, 0, 5'd0, 32'h0); settle();
    check("x0_read", 192'(dif.RD1E), 192'(0));
    drive(0, 32'h402081B3, 0, 0, 5'd0, 32'h0); settle();
    check("sub_alu", 192'(dif.ALUControlE), 192'(3'b001));

    // beq -4 and jal +8.
    drive(0, 32'hFE000EE3, 0, 0, 5'd0, 32'h0); settle();
    check("beq_br", 192'({dif.BranchE, dif.RegWriteE}), 192'(2'b10));
    check("beq_imm", 192'(dif.ImmExtE), 192'(32'hFFFFFFFC));
    drive(0, 32'h008000EF, 0, 0, 5'd0, 32'h0); settle();
    check("jal_ctl", 192'({dif.JumpE, dif.ResultSrcE}), 192'(3'b110));
    check("jal_imm", 192'(dif.ImmExtE), 192'(32'h8));

    // lw -8: flushed first, then loaded.
    dif.PCD = 32'h100; dif.PCPlus4D = 32'h104;
    drive(0, 32'hFF80A103, 1, 0, 5'd0, 32'h0); settle();
    check("flush_zero", 192'(dut_pack()), 192'(0));
    drive(0, 32'hFF80A103, 0, 0, 5'd0, 32'h0); settle();
    check("lw_ctl", 192'({dif.ResultSrcE, dif.ALUSrcE}), 192'(3'b011));
    check("lw_imm", 192'(dif.ImmExtE), 192'(32'hFFFFFFF8));
    check("lw_pc", 192'({dif.PCE, dif.PCPlus4E}), 192'({32'h100, 32'h104}));

    // Reset over a valid sw with a pending write: bubble, and writes lost.
    drive(0, 32'h0093A223, 0, 1, 5'd7, 32'h55); settle();
    check("sw_valid", 192'(dif.MemWriteE), 192'(1));
    drive(1, 32'h0093A223, 0, 1, 5'd9, 32'hAA); settle();
    check("rst_zero", 192'(dut_pack()), 192'(0));
    drive(0, 32'h009380B3, 0, 0, 5'd0, 32'h0); settle();
    check("rst_cleared", 192'({dif.RD1E, dif.RD2E}), 192'(0));

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] ins;
      logic [4:0]  rdw;
      int k;
      ins = $urandom;
      k   = $urandom_range(0, 7);
      case (k)
        0: ins[6:0] = 7'b0000011;
        1: ins[6:0] = 7'b0100011;
        2: begin ins[6:0] = 7'b0110011; ins[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00; end
        3: ins[6:0] = 7'b1100011;
        4: ins[6:0] = 7'b0010011;
        5: ins[6:0] = 7'b1101111;
        6: ins[6:0] = 7'b0110011;
        default: ;
      endcase
      case ($urandom_range(0, 3))
        0: rdw = ins[19:15];
        1: rdw = ins[24:20];
        default: rdw = 5'($urandom);
      endcase
      dif.PCD      = $urandom;
      dif.PCPlus4D = dif.PCD + 32'd4;
      drive(($urandom_range(0, 63) == 0), ins, ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 2) != 0), rdw, $urandom);
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
